// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// MMIO register offsets and the fixed-priority selector.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

  localparam int unsigned ID_W = 4;

  localparam logic [1:0] ENABLE_OFS  = 2'd0;
  localparam logic [1:0] PENDING_OFS = 2'd1;
  localparam logic [1:0] STATUS_OFS  = 2'd2;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [ID_W-1:0] lowest_set(input logic [15:0] v);
    logic [ID_W-1:0] id;
    logic            found;
    id    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!found && v[i]) begin
        id    = ID_W'(i);
        found = 1'b1;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bus bundle between the interrupt controller, the MCU control FSM / CSR
// unit and the firmware MMIO port.
interface intr_ctrl_if
  import intr_pkg::*;
#(
  parameter int unsigned N_SRC = 8
);

  logic [N_SRC-1:0] IRQ_IN;
  logic             CSR_MSTATUS;
  logic             CSR_MRET;
  logic             INT_ACK;
  logic             INT_REQ;
  logic [ID_W-1:0]  INT_ID;
  logic             MMIO_WE;
  logic [1:0]       MMIO_ADDR;
  logic [31:0]      MMIO_WD;
  logic [31:0]      MMIO_RD;

  modport slave (
    input  IRQ_IN, CSR_MSTATUS, CSR_MRET, INT_ACK, MMIO_WE, MMIO_ADDR, MMIO_WD,
    output INT_REQ, INT_ID, MMIO_RD
  );

  modport master (
    output IRQ_IN, CSR_MSTATUS, CSR_MRET, INT_ACK, MMIO_WE, MMIO_ADDR, MMIO_WD,
    input  INT_REQ, INT_ID, MMIO_RD
  );

endinterface

// File: rtl/intr_sync.sv
// Multi-stage synchroniser for one asynchronous interrupt line, with a
// one-cycle pulse on each rising edge of the synchronised level.
module intr_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // History resets low so a line held high through reset yields one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected pending bits, enable mask, fixed
// priority arbitration, REQ/ACK handshake, in-service tracking, MMIO window.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  intr_ctrl_if.slave   bus
);

  intr_state_t      r_state;
  intr_state_t      w_state_nxt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_id_nxt;
  logic [N_SRC-1:0] r_en;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_id_mask;
  logic             w_id_live;
  logic [31:0]      w_rd;
  logic             w_unused_wd;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    intr_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_async(bus.IRQ_IN[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_elig      = r_pend & r_en;
  assign w_id_mask   = N_SRC'(1) << r_id;
  assign w_id_live   = |(r_pend & r_en & w_id_mask);
  assign w_unused_wd = ^bus.MMIO_WD[31:N_SRC];

  always_comb begin
    w_clr = '0;
    if (bus.MMIO_WE && bus.MMIO_ADDR == PENDING_OFS)
      w_clr = bus.MMIO_WD[N_SRC-1:0];
    if (r_state == REQ && bus.INT_ACK)
      w_clr = w_clr | w_id_mask;
  end

  // Set is OR-ed in after the clear so a fresh edge survives ACK/W1C.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend <= '0;
      r_en   <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (bus.MMIO_WE && bus.MMIO_ADDR == ENABLE_OFS)
        r_en <= bus.MMIO_WD[N_SRC-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // ACK is tested first so it wins over a simultaneous MIE drop.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      IDLE: begin
        if (|w_elig && bus.CSR_MSTATUS) begin
          w_state_nxt = REQ;
          w_id_nxt    = lowest_set(16'(w_elig));
        end
      end
      REQ: begin
        if (bus.INT_ACK)
          w_state_nxt = SERVICE;
        else if (!bus.CSR_MSTATUS || !w_id_live)
          w_state_nxt = IDLE;
      end
      SERVICE: begin
        if (bus.CSR_MRET)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rd = '0;
    case (bus.MMIO_ADDR)
      ENABLE_OFS:  w_rd = 32'(r_en);
      PENDING_OFS: w_rd = 32'(r_pend);
      STATUS_OFS:  w_rd = {r_state == SERVICE, r_state == REQ, 26'd0, r_id};
      default:     w_rd = '0;
    endcase
  end

  assign bus.INT_REQ = (r_state == REQ);
  assign bus.INT_ID  = r_id;
  assign bus.MMIO_RD = w_rd;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_intr_ctrl;

  localparam int N = 8;
  localparam int S = 2;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  intr_ctrl_if #(.N_SRC(N)) bus ();

  intr_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending/enable words, handshake phase, served id
  // and a delay line of IRQ_IN words seen at each clock edge.
  bit [7:0] m_en;
  bit [7:0] m_pend;
  int       m_mode;
  int       m_id;
  bit [7:0] m_seen[$];

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {24'd0, m_en};
      2'd1: return {24'd0, m_pend};
      2'd2: return {m_mode == M_SVC, m_mode == M_REQ, 26'd0, 4'(m_id)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_tick();
    bit [7:0] rise, clr, en_now, pend_now;
    if (rst) begin
      m_en = 0; m_pend = 0; m_mode = M_IDLE; m_id = 0;
      m_seen.delete();
      repeat (S + 1) m_seen.push_back(8'h00);
      return;
    end
    // A source rises when the word seen S edges ago is high and the one before it was low.
    rise = m_seen[S-1] & ~m_seen[S];
    clr  = 0;
    if (bus.MMIO_WE && bus.MMIO_ADDR == 2'd1) clr = bus.MMIO_WD[7:0];
    if (m_mode == M_REQ && bus.INT_ACK) clr[m_id] = 1'b1;
    en_now   = m_en;
    pend_now = m_pend;
    m_pend   = (m_pend & ~clr) | rise;
    if (bus.MMIO_WE && bus.MMIO_ADDR == 2'd0) m_en = bus.MMIO_WD[7:0];
    case (m_mode)
      M_IDLE: if ((pend_now & en_now) != 0 && bus.CSR_MSTATUS) begin
        m_mode = M_REQ;
        m_id   = lowest(pend_now & en_now);
      end
      M_REQ: begin
        if (bus.INT_ACK) m_mode = M_SVC;
        else if (!bus.CSR_MSTATUS || !en_now[m_id] || !pend_now[m_id]) m_mode = M_IDLE;
      end
      default: if (bus.CSR_MRET) m_mode = M_IDLE;
    endcase
    m_seen.push_front(bus.IRQ_IN);
    void'(m_seen.pop_back());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check("model_req", {31'd0, bus.INT_REQ}, {31'd0, m_mode == M_REQ});
    check("model_id", {28'd0, bus.INT_ID}, 32'(m_id));
    check("model_rd", bus.MMIO_RD, model_rd(bus.MMIO_ADDR));
    bus.INT_ACK  = 1'b0;
    bus.CSR_MRET = 1'b0;
    bus.MMIO_WE  = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.IRQ_IN = '0; bus.CSR_MSTATUS = 1'b0; bus.INT_ACK = 1'b0; bus.CSR_MRET = 1'b0;
    bus.MMIO_WE = 1'b0; bus.MMIO_ADDR = 2'd0; bus.MMIO_WD = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic mmio_wr(input logic [1:0] a, input logic [31:0] d);
    bus.MMIO_WE = 1'b1; bus.MMIO_ADDR = a; bus.MMIO_WD = d;
    step();
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.MMIO_ADDR = a;
    #1;
    check(name, bus.MMIO_RD, exp);
  endtask

  task automatic req_chk(input string name, input logic req, input logic [3:0] id);
    check({name, "_req"}, {31'd0, bus.INT_REQ}, {31'd0, req});
    if (req) check({name, "_id"}, {28'd0, bus.INT_ID}, {28'd0, id});
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        ms, ack, mret, we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        req;
    logic [3:0]  id;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 1'b0, 4'd0, 32'h0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h1, 1'b0, 4'd0, 32'h1};
    tbl[2] = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 1'b0, 4'd0, 32'h0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 1'b0, 4'd0, 32'h0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 1'b0, 4'd0, 32'h1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 1'b1, 4'd0, 32'h4000_0000};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 1'b0, 4'd0, 32'h8000_0000};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 1'b0, 4'd0, 32'h0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0, 1'b0, 4'd0, 32'h0};

    repeat (S + 1) m_seen.push_back(8'h00);
    bus.IRQ_IN = '0; bus.CSR_MSTATUS = 1'b0; bus.INT_ACK = 1'b0; bus.CSR_MRET = 1'b0;
    bus.MMIO_WE = 1'b0; bus.MMIO_ADDR = 2'd0; bus.MMIO_WD = '0;
    #2;

    // Single source latency and full handshake.
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; bus.IRQ_IN = tbl[i].irq; bus.CSR_MSTATUS = tbl[i].ms;
      bus.INT_ACK = tbl[i].ack; bus.CSR_MRET = tbl[i].mret; bus.MMIO_WE = tbl[i].we;
      bus.MMIO_ADDR = tbl[i].addr; bus.MMIO_WD = tbl[i].wd;
      step();
      check($sformatf("tbl%0d_req", i), {31'd0, bus.INT_REQ}, {31'd0, tbl[i].req});
      check($sformatf("tbl%0d_id", i), {28'd0, bus.INT_ID}, {28'd0, tbl[i].id});
      check($sformatf("tbl%0d_rd", i), bus.MMIO_RD, tbl[i].rd);
    end
    rst = 1'b0;

    // Simultaneous sources: priority, then the loser after MRET.
    do_reset();
    mmio_wr(2'd0, 32'hFF);
    bus.CSR_MSTATUS = 1'b1; bus.IRQ_IN = 8'h24;
    steps(3);
    req_chk("prio_wait", 1'b0, 4'd0);
    step();
    req_chk("prio_first", 1'b1, 4'd2);
    bus.INT_ACK = 1'b1; step();
    rd_chk("prio_pend", 2'd1, 32'h20);
    bus.CSR_MRET = 1'b1; step();
    step();
    req_chk("prio_second", 1'b1, 4'd5);
    bus.INT_ACK = 1'b1; step();
    bus.CSR_MRET = 1'b1; step();

    // Masked source stays pending; enabling it requests; W1C withdraws it.
    do_reset();
    bus.CSR_MSTATUS = 1'b1; bus.IRQ_IN = 8'h08;
    steps(4);
    rd_chk("mask_pend", 2'd1, 32'h08);
    req_chk("mask_noreq", 1'b0, 4'd0);
    mmio_wr(2'd0, 32'h08);
    step();
    req_chk("mask_en", 1'b1, 4'd3);
    mmio_wr(2'd1, 32'h08);
    step();
    req_chk("mask_w1c", 1'b0, 4'd0);
    rd_chk("mask_w1c_pend", 2'd1, 32'h00);

    // MIE drop in REQ withdraws the request but keeps the pending bit.
    do_reset();
    bus.CSR_MSTATUS = 1'b1;
    mmio_wr(2'd0, 32'h02);
    bus.IRQ_IN = 8'h02;
    steps(3);
    step();
    req_chk("mie_req", 1'b1, 4'd1);
    bus.CSR_MSTATUS = 1'b0; step();
    req_chk("mie_drop", 1'b0, 4'd0);
    rd_chk("mie_pend", 2'd1, 32'h02);
    bus.CSR_MSTATUS = 1'b1; step();
    req_chk("mie_reissue", 1'b1, 4'd1);

    // New edge on the acknowledged source in the ACK cycle is kept.
    bus.IRQ_IN = 8'h00; steps(3);
    bus.IRQ_IN = 8'h02; steps(2);
    bus.INT_ACK = 1'b1; step();
    rd_chk("coll_pend", 2'd1, 32'h02);
    rd_chk("coll_status", 2'd2, 32'h8000_0001);
    bus.CSR_MRET = 1'b1; step();
    step();
    req_chk("coll_second", 1'b1, 4'd1);

    // Reset during SERVICE, line held high across it.
    bus.INT_ACK = 1'b1; step();
    rd_chk("svc_status", 2'd2, 32'h8000_0001);
    rst = 1'b1; step();
    rst = 1'b0;
    rd_chk("rst_status", 2'd2, 32'h0);
    rd_chk("rst_pend", 2'd1, 32'h0);
    rd_chk("rst_en", 2'd0, 32'h0);
    req_chk("rst_req", 1'b0, 4'd0);
    steps(3);
    rd_chk("held_edge", 2'd1, 32'h02);
    mmio_wr(2'd1, 32'h02);
    steps(4);
    rd_chk("held_once", 2'd1, 32'h00);
    rd_chk("addr3", 2'd3, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.IRQ_IN = bus.IRQ_IN ^ 8'(1 << $urandom_range(0, 7));
      bus.CSR_MSTATUS = ($urandom_range(0, 9) != 0);
      bus.INT_ACK  = (m_mode == M_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      bus.CSR_MRET = (m_mode == M_SVC) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      bus.MMIO_WE   = ($urandom_range(0, 7) == 0);
      bus.MMIO_ADDR = 2'($urandom_range(0, 3));
      bus.MMIO_WD   = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
